// File: rtl/io_input_manager.sv
// Memory-mapped switch/key input block: 2-FF sync, tick-sampled debounce, sticky press flags.
// Optional IRQ mask register and interrupt output enabled by defining IO_IRQ_EN.
module io_input_manager #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter logic [15:0] MASK_ADDR       = 16'hFFFA,
   parameter logic [15:0] EDGE_ADDR       = 16'hFFFB,
   parameter logic [15:0] KEY_ADDR        = 16'hFFFC,
   parameter logic [15:0] SW_ADDR         = 16'hFFFD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] dir_in,
   input  logic        oe,
   input  logic [9:0]  SW,
   input  logic [3:0]  KEY,
   inout  wire  [15:0] data_inout,
   output logic        sel,
   output logic        irq
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [9:0]    sw_meta, sw_sync, sw_prev, stable_sw;
   logic [3:0]    key_meta, key_sync, key_prev, stable_key, stable_key_d;
   logic [3:0]    flag, press;
   logic [CW-1:0] count;
   logic          tick;
   logic          hit, drive, edge_clr;
   logic [15:0]   rd_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         key_meta <= '0;
         key_sync <= '0;
      end else begin
         sw_meta  <= SW;
         sw_sync  <= sw_meta;
         key_meta <= ~KEY;
         key_sync <= key_meta;
      end
   end

   assign tick = (count == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   // A bit only moves to stable after two consecutive ticks saw the same level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_prev    <= '0;
         stable_sw  <= '0;
         key_prev   <= '0;
         stable_key <= '0;
      end else if (tick) begin
         sw_prev  <= sw_sync;
         key_prev <= key_sync;
         for (int unsigned i = 0; i < 10; i++) begin
            if (sw_prev[i] == sw_sync[i]) stable_sw[i] <= sw_sync[i];
         end
         for (int unsigned i = 0; i < 4; i++) begin
            if (key_prev[i] == key_sync[i]) stable_key[i] <= key_sync[i];
         end
      end
   end

   assign press    = stable_key & ~stable_key_d;
   assign edge_clr = (dir_in == EDGE_ADDR) && !oe;

   // The clearing read keeps a press arriving on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable_key_d <= '0;
         flag         <= '0;
      end else begin
         stable_key_d <= stable_key;
         if (edge_clr) flag <= press;
         else          flag <= flag | press;
      end
   end

`ifdef IO_IRQ_EN
   logic [3:0] mask;
   logic       irq_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask  <= '0;
         irq_q <= 1'b0;
      end else begin
         if ((dir_in == MASK_ADDR) && oe) mask <= data_inout[3:0];
         irq_q <= |(flag & mask);
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rd_data = '0;
      hit     = 1'b0;
      if (dir_in == SW_ADDR) begin
         rd_data = {6'b0, stable_sw};
         hit     = 1'b1;
      end else if (dir_in == KEY_ADDR) begin
         rd_data = {12'b0, stable_key};
         hit     = 1'b1;
      end else if (dir_in == EDGE_ADDR) begin
         rd_data = {12'b0, flag};
         hit     = 1'b1;
      end
`ifdef IO_IRQ_EN
      else if (dir_in == MASK_ADDR) begin
         rd_data = {12'b0, mask};
         hit     = 1'b1;
      end
`endif
   end

   assign sel        = hit;
   assign drive      = hit && !oe && reset;
   assign data_inout = drive ? rd_data : 16'bz;

endmodule
